pri_scan_seq: RTL and testbench
===============================

PRI_SCAN_SEQ -- requirements
Module: pri_scan_seq

Interface
REQ-001 The block SHALL have parameter NUM_ELEMENTS, default 14, giving the input vector width (legal range 2..64).
REQ-002 The block SHALL have parameter IDX_W, default 4, giving the index width; IDX_W SHALL equal clog2(NUM_ELEMENTS).
REQ-003 The block SHALL have parameter RIGHT_FIRST, default 0. Value 0 reports the leftmost (lowest index) bit first; value 1 reports the rightmost (highest index) bit first.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  a section vector is offered.
REQ-007 section  input  [0:NUM_ELEMENTS-1]  vector to scan; index 0 is leftmost.
REQ-008 in_ready  output  1  block can accept a vector.
REQ-009 flush  input  1  synchronous abort of the current scan.
REQ-010 out_valid  output  1  out_index/out_ord/out_last/out_none are valid.
REQ-011 out_ready  input  1  consumer accepts the current result.
REQ-012 out_index  output  IDX_W  position of the reported set bit.
REQ-013 out_ord  output  IDX_W+1  zero-based ordinal of the reported bit within the vector.
REQ-014 out_last  output  1  the current beat is the final beat for the vector.
REQ-015 out_none  output  1  the accepted vector was all-zero.
REQ-016 active  output  1  registered flag: the last accepted vector was non-zero.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, SCAN and EMPTY.
REQ-018 in_ready SHALL be 1 only in IDLE, and only when flush=0.
REQ-019 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1. On accept, section SHALL be latched into the mask register, out_ord SHALL clear to 0, and active SHALL be set to (section!=0).
REQ-020 Accept of a non-zero vector SHALL move the FSM to SCAN. Accept of a zero vector SHALL move it to EMPTY.
REQ-021 out_valid SHALL be 1 in SCAN and EMPTY and 0 in IDLE, so the first result appears in the cycle after accept (latency 1).
REQ-022 In SCAN, out_index SHALL be the lowest set index of the mask (highest if RIGHT_FIRST=1), decoded combinationally from the mask register.
REQ-023 In SCAN, out_last SHALL be 1 when exactly one mask bit remains set.
REQ-024 In EMPTY, out_none=1, out_last=1, out_index=0 and out_ord=0. Otherwise out_none=0.
REQ-025 A handshake SHALL occur on a rising edge where out_valid=1 and out_ready=1. In SCAN the handshake SHALL clear the reported mask bit and increment out_ord by 1.
REQ-026 A handshake with out_last=1 SHALL return the FSM to IDLE; in_ready rises in the next cycle.
REQ-027 While out_valid=1 and out_ready=0, out_index, out_ord, out_last and out_none SHALL hold stable.
REQ-028 A vector with K set bits SHALL produce exactly K beats, in strict scan order, with no gaps while out_ready=1. The ordinals SHALL be 0..K-1.
REQ-029 flush=1 SHALL force IDLE on the next edge and clear the mask and out_ord. flush SHALL take priority over any same-edge accept or handshake, and no accept SHALL occur while flush=1.
REQ-030 In IDLE, out_index and out_ord SHALL read 0, and out_last=0.
REQ-031 section SHALL be ignored outside accept edges; changes mid-scan have no effect.
REQ-032 With all NUM_ELEMENTS bits set, out_ord SHALL reach NUM_ELEMENTS-1 without overflow.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE, and mask, out_ord, active, out_valid, out_last and out_none SHALL all be 0. in_ready SHALL be 1.
REQ-034 Reset SHALL take effect asynchronously, including mid-scan, with no result beat emitted afterwards.
REQ-035 Release of rst_n SHALL be treated as synchronous to clk; the first accept is possible on the first rising edge after release.

Verification
REQ-036 Default params, section bits 2, 5 and 13 set, out_ready=1 -> beats (2,0), (5,1), (13,2,last), then in_ready=1 on the next cycle.
REQ-037 RIGHT_FIRST=1, same vector -> beats (13,0), (5,1), (2,2,last).
REQ-038 section=0 -> one beat with out_none=1, out_last=1, out_index=0; active=0.
REQ-039 Vector with bits 0 and 1 set, out_ready low for 3 cycles -> outputs held at (0,0), then (0,0) and (1,1,last) once out_ready rises.
REQ-040 flush asserted on the second beat of a 4-bit vector -> next cycle IDLE, out_valid=0; a new vector is accepted normally afterwards.
REQ-041 rst_n pulsed low mid-scan -> out_valid drops immediately with no clock edge, and all outputs are at reset values.

Source files
------------

// File: rtl/pri_scan_seq.sv
// Priority scanner: latches a bit vector and streams out the index of each set
// bit, one beat per handshake, in left-first or right-first order.
module pri_scan_seq #(
    parameter int NUM_ELEMENTS = 14,
    parameter int IDX_W        = 4,
    parameter bit RIGHT_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [0:NUM_ELEMENTS-1] section,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic [IDX_W:0]        out_ord,
    output logic                  out_last,
    output logic                  out_none,
    output logic                  active
);

    typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_t;

    localparam logic [IDX_W:0] ORD_ONE = 1;

    state_t                    state_q;
    logic [0:NUM_ELEMENTS-1]   mask_q;
    logic [IDX_W:0]            ord_q;
    logic                      active_q;

    logic [IDX_W-1:0]          enc;
    logic                      seen;
    logic                      multi;
    logic                      one_left;

    // Priority encode the surviving mask; the loop that writes last wins.
    always_comb begin
        enc = '0;
        if (RIGHT_FIRST) begin
            for (int i = 0; i < NUM_ELEMENTS; i++)
                if (mask_q[i]) enc = IDX_W'(i);
        end else begin
            for (int i = NUM_ELEMENTS - 1; i >= 0; i--)
                if (mask_q[i]) enc = IDX_W'(i);
        end
    end

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (mask_q[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        one_left = seen && !multi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            ord_q    <= '0;
            active_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ord_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mask_q   <= section;
                    ord_q    <= '0;
                    active_q <= |section;
                    state_q  <= (|section) ? SCAN : EMPTY;
                end
                SCAN: if (out_ready) begin
                    mask_q[enc] <= 1'b0;
                    ord_q       <= ord_q + ORD_ONE;
                    if (one_left) state_q <= IDLE;
                end
                EMPTY: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result fields are forced to zero outside the state that gives them meaning.
    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q != IDLE);
    assign out_index = (state_q == SCAN) ? enc : '0;
    assign out_ord   = (state_q == SCAN) ? ord_q : '0;
    assign out_last  = (state_q == EMPTY) || ((state_q == SCAN) && one_left);
    assign out_none  = (state_q == EMPTY);
    assign active    = active_q;

endmodule

// File: tb/tb_pri_scan_seq.sv
// Directed bench for pri_scan_seq: a left-first and a right-first instance
// share stimulus; each task checks its own scenario against hand-worked beats.
module tb_pri_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [0:13] section;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  r_in_ready;
    logic        out_valid, r_out_valid;
    logic [3:0]  out_index, r_out_index;
    logic [4:0]  out_ord,   r_out_ord;
    logic        out_last,  r_out_last;
    logic        out_none,  r_out_none;
    logic        active,    r_active;

    int nvec = 0;
    int nerr = 0;

    // {valid, index, ord, last, none}
    logic [11:0] beat, r_beat;
    assign beat   = {out_valid, out_index, out_ord, out_last, out_none};
    assign r_beat = {r_out_valid, r_out_index, r_out_ord, r_out_last, r_out_none};

    always #5 clk = ~clk;

    pri_scan_seq #(.NUM_ELEMENTS(14), .IDX_W(4), .RIGHT_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .section(section),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_ord(out_ord),
        .out_last(out_last), .out_none(out_none), .active(active)
    );

    pri_scan_seq #(.NUM_ELEMENTS(14), .IDX_W(4), .RIGHT_FIRST(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .section(section),
        .in_ready(r_in_ready), .flush(flush), .out_valid(r_out_valid),
        .out_ready(out_ready), .out_index(r_out_index), .out_ord(r_out_ord),
        .out_last(r_out_last), .out_none(r_out_none), .active(r_active)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; section = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        nvec++;
        if (beat !== 12'h000) begin
            $display("FAIL reset_beat got %h exp %h", beat, 12'h000); nerr++;
        end
        nvec++;
        if ({in_ready, active} !== 2'b10) begin
            $display("FAIL reset_rdy_act got %b exp %b", {in_ready, active}, 2'b10); nerr++;
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        logic [11:0] exp [3];
        exp[0] = {1'b1, 4'd2,  5'd0, 1'b0, 1'b0};
        exp[1] = {1'b1, 4'd5,  5'd1, 1'b0, 1'b0};
        exp[2] = {1'b1, 4'd13, 5'd2, 1'b1, 1'b0};
        section = '0; section[2] = 1'b1; section[5] = 1'b1; section[13] = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        nvec++;
        if (active !== 1'b1) begin
            $display("FAIL basic_active got %b exp 1", active); nerr++;
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (beat !== exp[i]) begin
                $display("FAIL basic_beat%0d got %h exp %h", i, beat, exp[i]); nerr++;
            end
            tick;
        end
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL basic_idle got %b exp %b", {out_valid, in_ready}, 2'b01); nerr++;
        end
    endtask

    task automatic test_right_first;
        logic [11:0] exp [3];
        exp[0] = {1'b1, 4'd13, 5'd0, 1'b0, 1'b0};
        exp[1] = {1'b1, 4'd5,  5'd1, 1'b0, 1'b0};
        exp[2] = {1'b1, 4'd2,  5'd2, 1'b1, 1'b0};
        section = '0; section[2] = 1'b1; section[5] = 1'b1; section[13] = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (r_beat !== exp[i]) begin
                $display("FAIL rf_beat%0d got %h exp %h", i, r_beat, exp[i]); nerr++;
            end
            tick;
        end
        nvec++;
        if (r_out_valid !== 1'b0) begin
            $display("FAIL rf_idle got %b exp 0", r_out_valid); nerr++;
        end
    endtask

    task automatic test_empty;
        section = '0; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        nvec++;
        if (beat !== {1'b1, 4'd0, 5'd0, 1'b1, 1'b1}) begin
            $display("FAIL empty_beat got %h exp %h", beat, {1'b1, 4'd0, 5'd0, 1'b1, 1'b1}); nerr++;
        end
        nvec++;
        if (active !== 1'b0) begin
            $display("FAIL empty_active got %b exp 0", active); nerr++;
        end
        tick;
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL empty_done got %b exp %b", {out_valid, in_ready}, 2'b01); nerr++;
        end
    endtask

    task automatic test_stall;
        section = '0; section[0] = 1'b1; section[1] = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        section = '1;  // must not disturb the scan in progress
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (beat !== {1'b1, 4'd0, 5'd0, 1'b0, 1'b0}) begin
                $display("FAIL stall_hold%0d got %h exp %h", i, beat, {1'b1, 4'd0, 5'd0, 1'b0, 1'b0}); nerr++;
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        nvec++;
        if (beat !== {1'b1, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            $display("FAIL stall_b0 got %h exp %h", beat, {1'b1, 4'd0, 5'd0, 1'b0, 1'b0}); nerr++;
        end
        tick;
        nvec++;
        if (beat !== {1'b1, 4'd1, 5'd1, 1'b1, 1'b0}) begin
            $display("FAIL stall_b1 got %h exp %h", beat, {1'b1, 4'd1, 5'd1, 1'b1, 1'b0}); nerr++;
        end
        tick;
        nvec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_end got %b exp 0", out_valid); nerr++;
        end
    endtask

    task automatic test_flush;
        section = '0; section[1] = 1'b1; section[3] = 1'b1; section[7] = 1'b1; section[10] = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        nvec++;
        if (beat !== {1'b1, 4'd3, 5'd1, 1'b0, 1'b0}) begin
            $display("FAIL flush_b1 got %h exp %h", beat, {1'b1, 4'd3, 5'd1, 1'b0, 1'b0}); nerr++;
        end
        flush = 1'b1; in_valid = 1'b1; section = '0; section[4] = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            $display("FAIL flush_rdy got %b exp 0", in_ready); nerr++;
        end
        tick;
        nvec++;
        if ({beat, in_ready} !== {12'h000, 1'b0}) begin
            $display("FAIL flush_idle got %h exp %h", {beat, in_ready}, {12'h000, 1'b0}); nerr++;
        end
        flush = 1'b0;
        #1;
        tick;
        in_valid = 1'b0;
        nvec++;
        if (beat !== {1'b1, 4'd4, 5'd0, 1'b1, 1'b0}) begin
            $display("FAIL flush_new got %h exp %h", beat, {1'b1, 4'd4, 5'd0, 1'b1, 1'b0}); nerr++;
        end
        tick;
    endtask

    task automatic test_full;
        section = '1; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            nvec++;
            if (beat !== {1'b1, 4'(i), 5'(i), (i == 13), 1'b0}) begin
                $display("FAIL full_b%0d got %h exp %h", i, beat, {1'b1, 4'(i), 5'(i), (i == 13), 1'b0}); nerr++;
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        section = '0; section[9] = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        section = '0; section[6] = 1'b1;
        nvec++;
        if ({beat, in_ready} !== {1'b1, 4'd9, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL b2b_first got %h exp %h", {beat, in_ready}, {1'b1, 4'd9, 5'd0, 1'b1, 1'b0, 1'b0}); nerr++;
        end
        tick;
        nvec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL b2b_rdy got %b exp 1", in_ready); nerr++;
        end
        tick;
        in_valid = 1'b0;
        nvec++;
        if (beat !== {1'b1, 4'd6, 5'd0, 1'b1, 1'b0}) begin
            $display("FAIL b2b_second got %h exp %h", beat, {1'b1, 4'd6, 5'd0, 1'b1, 1'b0}); nerr++;
        end
        tick;
    endtask

    task automatic test_reset_mid;
        section = '0; section[0] = 1'b1; section[6] = 1'b1; section[9] = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({beat, in_ready, active} !== {12'h000, 1'b1, 1'b0}) begin
            $display("FAIL rstmid_async got %h exp %h", {beat, in_ready, active}, {12'h000, 1'b1, 1'b0}); nerr++;
        end
        #3;
        rst_n = 1'b1;
        tick;
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL rstmid_after got %b exp %b", {out_valid, in_ready}, 2'b01); nerr++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_right_first;
        test_empty;
        test_stall;
        test_flush;
        test_full;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
